// File: rtl/regf_bus_arb_pkg.sv
// regf_bus_arb_pkg: shared widths, FSM states and command type for the regf bus arbiter
package regf_bus_arb_pkg;
  localparam int ADDR_WIDTH = 13;
  localparam int DATA_WIDTH = 32;
  typedef enum logic [1:0] {RUN, DRAIN, SRST} arb_state_e;
  typedef logic req_id_t;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wena;
    logic [DATA_WIDTH-1:0] wdata;
    req_id_t               id;
  } cmd_t;
endpackage

// File: rtl/regf_bus_arb_if.sv
// regf_bus_arb_if: two requester ports (index 0 host, 1 debug) plus the regf bus
//   req_valid/addr/wena/wdata -> arbiter, req_ready/rsp/rdata/err <- arbiter
//   mem_ena/addr/wena/wdata <- arbiter, mem_rdata/err -> arbiter
interface regf_bus_arb_if import regf_bus_arb_pkg::*; ();
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0]            req_wena;
  logic [1:0]            req_rsp;
  logic [1:0]            req_err;
  logic [ADDR_WIDTH-1:0] req_addr [2];
  logic [DATA_WIDTH-1:0] req_wdata [2];
  logic [DATA_WIDTH-1:0] req_rdata [2];
  logic                  mem_ena;
  logic                  mem_wena;
  logic                  mem_err;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  modport slave (
    input  req_valid, req_wena, req_addr, req_wdata, mem_rdata, mem_err,
    output req_ready, req_rsp, req_rdata, req_err, mem_ena, mem_wena, mem_addr, mem_wdata
  );
  modport master (
    output req_valid, req_wena, req_addr, req_wdata, mem_rdata, mem_err,
    input  req_ready, req_rsp, req_rdata, req_err, mem_ena, mem_wena, mem_addr, mem_wdata
  );
endinterface

// File: rtl/regf_bus_arb_rr.sv
// regf_bus_arb_rr: 2-way round-robin picker owning last_gnt
//   valid[1:0] requests, en gates all grants, accept advances last_gnt; gnt[1:0] one-hot or zero
module regf_bus_arb_rr (
  input  logic       main_clk_i,
  input  logic       main_rst_an_i,
  input  logic [1:0] valid,
  input  logic       en,
  input  logic       accept,
  output logic [1:0] gnt
);
  logic last_gnt, pick1;
  // With no or both requesters valid the side that did not win last is offered, so ready idles high on it
  always_comb pick1 = (valid[1] & ~valid[0]) | (~last_gnt & (valid[1] == valid[0]));
  always_comb gnt = en ? {pick1, ~pick1} : 2'b00;
  always_ff @(posedge main_clk_i or negedge main_rst_an_i)
    if (!main_rst_an_i) last_gnt <= 1'b1;
    else if (accept) last_gnt <= pick1;
endmodule

// File: rtl/regf_bus_arb.sv
// regf_bus_arb: round-robin share of one regf bus between host and debug, with soft-reset sequencing
//   main_clk_i/main_rst_an_i clock and async active-low reset, bus requester+regf signals,
//   swrst_req_i soft reset request pulse, swrst_busy_o sequence in progress, soft_rst_o to regf
module regf_bus_arb import regf_bus_arb_pkg::*; #(
  parameter int SRST_CYCLES = 4
) (
  input  logic          main_clk_i,
  input  logic          main_rst_an_i,
  input  logic          swrst_req_i,
  output logic          swrst_busy_o,
  output logic          soft_rst_o,
  regf_bus_arb_if.slave bus
);
  arb_state_e            state;
  logic [7:0]            cnt;
  logic [1:0]            gnt;
  logic                  en, accept, rsp_v, rsp_err;
  req_id_t               iss_id, rsp_id;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  cmd_t                  acc;
  assign en = state == RUN && !swrst_req_i;
  assign accept = |(bus.req_valid & gnt);
  assign bus.req_ready = gnt;
  assign acc = '{addr: bus.req_addr[gnt[1]], wena: bus.req_wena[gnt[1]], wdata: bus.req_wdata[gnt[1]], id: gnt[1]};
  assign swrst_busy_o = state != RUN || swrst_req_i;
  assign bus.req_rsp = rsp_v ? (rsp_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.req_err = bus.req_rsp & {2{rsp_err}};
  assign bus.req_rdata[0] = bus.req_rsp[0] ? rsp_rdata : '0;
  assign bus.req_rdata[1] = bus.req_rsp[1] ? rsp_rdata : '0;
  regf_bus_arb_rr u_rr (
    .main_clk_i   (main_clk_i),
    .main_rst_an_i(main_rst_an_i),
    .valid        (bus.req_valid),
    .en           (en),
    .accept       (accept),
    .gnt          (gnt)
  );
  // Issue stage is the mem_* flops; the regf answers combinationally, so capture in the issue cycle
  always_ff @(posedge main_clk_i or negedge main_rst_an_i)
    if (!main_rst_an_i) begin
      bus.mem_ena   <= 1'b0;
      bus.mem_wena  <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      iss_id        <= 1'b0;
      rsp_v         <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= '0;
    end else begin
      bus.mem_ena <= accept;
      if (accept) begin
        bus.mem_wena  <= acc.wena;
        bus.mem_addr  <= acc.addr;
        bus.mem_wdata <= acc.wdata;
        iss_id        <= acc.id;
      end
      rsp_v     <= bus.mem_ena;
      rsp_id    <= iss_id;
      rsp_err   <= bus.mem_ena & bus.mem_err;
      rsp_rdata <= bus.mem_wena ? '0 : bus.mem_rdata;
    end
  always_ff @(posedge main_clk_i or negedge main_rst_an_i)
    if (!main_rst_an_i) begin
      state      <= RUN;
      cnt        <= '0;
      soft_rst_o <= 1'b0;
    end else begin
      case (state)
        RUN: if (swrst_req_i) state <= DRAIN;
        DRAIN: if (!bus.mem_ena && !rsp_v) begin
          state      <= SRST;
          cnt        <= 8'(SRST_CYCLES - 1);
          soft_rst_o <= 1'b1;
        end
        SRST: if (cnt == 8'd0) begin
          state      <= RUN;
          soft_rst_o <= 1'b0;
        end else cnt <= cnt - 8'd1;
        default: state <= RUN;
      endcase
    end
endmodule
